// File: rtl/hazard_bubble_ctrl.sv
// Load-use hazard bubble injector and taken-branch IF/ID flush for the ID stage, with debug counters.
// Latency: control outputs are combinational from state and inputs; state and counters update on posedge.
// Backpressure: a hazard holds PC and IF/ID and bubbles ID/EX for exactly LOAD_STALL_CYCLES cycles.
module hazard_bubble_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IFID_rs_i,
    input  logic [4:0]       IFID_rt_i,
    input  logic             uses_rt_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_rt_i,
    input  logic             branch_taken_i,
    input  logic [1:0]       ctrl_WB_i,
    input  logic [1:0]       ctrl_M_i,
    input  logic [3:0]       ctrl_EX_i,
    output logic [1:0]       ctrl_WB_o,
    output logic [1:0]       ctrl_M_o,
    output logic [3:0]       ctrl_EX_o,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] remain, remain_nxt;
    logic       hz;
    logic       bubble;
    logic       flush_evt;

    // Load in EX writes a register the ID instruction reads; $zero is never a real dependency.
    always_comb begin
        hz = IDEX_MemRead_i && (IDEX_rt_i != 5'd0) &&
             ((IDEX_rt_i == IFID_rs_i) || (uses_rt_i && (IDEX_rt_i == IFID_rt_i)));
    end

    // Next state and event decode; branch is ignored while bubbling since its operands may be stale.
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        bubble     = 1'b0;
        flush_evt  = 1'b0;
        case (state)
            RUN: begin
                if (hz) begin
                    bubble = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_nxt  = STALL;
                        remain_nxt = 4'(LOAD_STALL_CYCLES - 1);
                    end
                end else if (branch_taken_i) begin
                    flush_evt = 1'b1;
                end
            end
            STALL: begin
                bubble = 1'b1;
                if (remain == 4'd1) begin
                    state_nxt = RUN;
                end
                remain_nxt = remain - 4'd1;
            end
            default: begin
                state_nxt  = RUN;
                remain_nxt = 4'd0;
            end
        endcase
    end

    // Control fields to ID/EX and pipeline enables; everything held low while in reset.
    always_comb begin
        ctrl_WB_o    = 2'b00;
        ctrl_M_o     = 2'b00;
        ctrl_EX_o    = 4'b0000;
        PC_write_o   = 1'b0;
        IFID_write_o = 1'b0;
        IFID_flush_o = 1'b0;
        if (rst_i && !bubble) begin
            ctrl_WB_o    = ctrl_WB_i;
            ctrl_M_o     = ctrl_M_i;
            ctrl_EX_o    = ctrl_EX_i;
            PC_write_o   = 1'b1;
            IFID_write_o = 1'b1;
            IFID_flush_o = flush_evt;
        end
    end

    // State and remaining-bubble register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= RUN;
            remain <= 4'd0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
        end
    end

    // Saturating debug counters: one count per bubble cycle and per flush issued.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (bubble && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (flush_evt && (flush_cnt_o != {CNT_W{1'b1}})) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Bench for hazard_bubble_ctrl: three configurations share one directed input stream.
// A bubble-count model is compared against every instance on each negedge; literal checks pin key points.
// Instances: a = 1 bubble/16-bit counters, b = 3 bubbles/16-bit, c = 2 bubbles/2-bit counters.
module tb_hazard_bubble_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs = '0, rt = '0, idex_rt = '0;
    logic       uses_rt = 1'b0, memread = 1'b0, br = 1'b0;
    logic [1:0] wb = '0, m = '0;
    logic [3:0] ex = '0;

    logic [2:0][1:0]  wb_o, m_o, st_o;
    logic [2:0][3:0]  ex_o;
    logic [2:0]       pc_o, ifw_o, fl_o;
    logic [2:0][15:0] sc_o, fc_o;
    logic [1:0]       c_sc, c_fc;

    int checks = 0;
    int failures = 0;
    bit running = 1'b0;

    int loads [3] = '{1, 3, 2};
    int maxc  [3] = '{65535, 65535, 3};
    int busy  [3] = '{0, 0, 0};
    int scnt  [3] = '{0, 0, 0};
    int fcnt  [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    hazard_bubble_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .IFID_rs_i(rs), .IFID_rt_i(rt), .uses_rt_i(uses_rt),
        .IDEX_MemRead_i(memread), .IDEX_rt_i(idex_rt), .branch_taken_i(br),
        .ctrl_WB_i(wb), .ctrl_M_i(m), .ctrl_EX_i(ex),
        .ctrl_WB_o(wb_o[0]), .ctrl_M_o(m_o[0]), .ctrl_EX_o(ex_o[0]), .PC_write_o(pc_o[0]),
        .IFID_write_o(ifw_o[0]), .IFID_flush_o(fl_o[0]), .state_o(st_o[0]),
        .stall_cnt_o(sc_o[0]), .flush_cnt_o(fc_o[0]));

    hazard_bubble_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .IFID_rs_i(rs), .IFID_rt_i(rt), .uses_rt_i(uses_rt),
        .IDEX_MemRead_i(memread), .IDEX_rt_i(idex_rt), .branch_taken_i(br),
        .ctrl_WB_i(wb), .ctrl_M_i(m), .ctrl_EX_i(ex),
        .ctrl_WB_o(wb_o[1]), .ctrl_M_o(m_o[1]), .ctrl_EX_o(ex_o[1]), .PC_write_o(pc_o[1]),
        .IFID_write_o(ifw_o[1]), .IFID_flush_o(fl_o[1]), .state_o(st_o[1]),
        .stall_cnt_o(sc_o[1]), .flush_cnt_o(fc_o[1]));

    hazard_bubble_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(2)) dut_c (
        .clk_i(clk), .rst_i(rst), .IFID_rs_i(rs), .IFID_rt_i(rt), .uses_rt_i(uses_rt),
        .IDEX_MemRead_i(memread), .IDEX_rt_i(idex_rt), .branch_taken_i(br),
        .ctrl_WB_i(wb), .ctrl_M_i(m), .ctrl_EX_i(ex),
        .ctrl_WB_o(wb_o[2]), .ctrl_M_o(m_o[2]), .ctrl_EX_o(ex_o[2]), .PC_write_o(pc_o[2]),
        .IFID_write_o(ifw_o[2]), .IFID_flush_o(fl_o[2]), .state_o(st_o[2]),
        .stall_cnt_o(c_sc), .flush_cnt_o(c_fc));

    assign sc_o[2] = {14'd0, c_sc};
    assign fc_o[2] = {14'd0, c_fc};

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h exp=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic bit hazard();
        return memread && (idex_rt != 5'd0) &&
               ((idex_rt == rs) || (uses_rt && (idex_rt == rt)));
    endfunction

    // Model: a hazard in free-running mode costs `load` bubble cycles in total; busy counts the ones still owed.
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                busy[k] = 0; scnt[k] = 0; fcnt[k] = 0;
            end else if (busy[k] > 0) begin
                busy[k]--;
                if (scnt[k] < maxc[k]) scnt[k]++;
            end else if (hazard()) begin
                busy[k] = loads[k] - 1;
                if (scnt[k] < maxc[k]) scnt[k]++;
            end else if (br) begin
                if (fcnt[k] < maxc[k]) fcnt[k]++;
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (running) begin
            for (int k = 0; k < 3; k++) begin
                bit bub;
                bit pass;
                bub  = (busy[k] > 0) || hazard();
                pass = rst && !bub;
                chk("ctrl_wb", k, 32'(wb_o[k]), pass ? 32'(wb) : 32'd0);
                chk("ctrl_m",  k, 32'(m_o[k]),  pass ? 32'(m)  : 32'd0);
                chk("ctrl_ex", k, 32'(ex_o[k]), pass ? 32'(ex) : 32'd0);
                chk("pc_write", k, 32'(pc_o[k]), 32'(pass));
                chk("ifid_write", k, 32'(ifw_o[k]), 32'(pass));
                chk("ifid_flush", k, 32'(fl_o[k]), 32'(pass && br));
                chk("state", k, 32'(st_o[k]), (rst && busy[k] > 0) ? 32'd1 : 32'd0);
                chk("stall_cnt", k, 32'(sc_o[k]), 32'(scnt[k]));
                chk("flush_cnt", k, 32'(fc_o[k]), 32'(fcnt[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memread = 1'b0; br = 1'b0; uses_rt = 1'b0;
        idex_rt = 5'd0; rs = 5'd1; rt = 5'd2;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // 1. Reset with random inputs, then release into pass-through.
        rs = 5'($urandom); rt = 5'($urandom); idex_rt = 5'($urandom);
        memread = 1'($urandom); uses_rt = 1'($urandom); br = 1'($urandom);
        wb = 2'($urandom); m = 2'($urandom); ex = 4'($urandom);
        running = 1'b1;
        @(negedge clk);
        chk("lit_rst_pc", 0, 32'(pc_o[0]), 32'd0);
        chk("lit_rst_state", 1, 32'(st_o[1]), 32'd0);
        tick();
        idle(); wb = 2'b10; m = 2'b01; ex = 4'b1011;
        rst = 1'b1;
        @(negedge clk);
        chk("lit_release_ex", 0, 32'(ex_o[0]), 32'hb);
        chk("lit_release_pc", 0, 32'(pc_o[0]), 32'd1);

        // 2. Load-use on rs.
        tick();
        memread = 1'b1; idex_rt = 5'd8; rs = 5'd8;
        @(negedge clk);
        chk("lit_rs_bubble_ex", 0, 32'(ex_o[0]), 32'd0);
        chk("lit_rs_bubble_pc", 0, 32'(pc_o[0]), 32'd0);
        tick();
        memread = 1'b0;
        @(negedge clk);
        chk("lit_rs_resume_ex", 0, 32'(ex_o[0]), 32'hb);
        chk("lit_rs_stall_cnt", 0, 32'(sc_o[0]), 32'd1);
        tick(); tick(); tick();

        // 3. rt match gated by uses_rt; $zero never stalls.
        memread = 1'b1; idex_rt = 5'd9; rt = 5'd9; rs = 5'd3; uses_rt = 1'b0;
        @(negedge clk);
        chk("lit_rt_nouse_pc", 0, 32'(pc_o[0]), 32'd1);
        tick();
        uses_rt = 1'b1;
        @(negedge clk);
        chk("lit_rt_use_pc", 0, 32'(pc_o[0]), 32'd0);
        tick();
        idex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
        @(negedge clk);
        chk("lit_zero_pc", 0, 32'(pc_o[0]), 32'd1);
        tick();
        idle(); tick(); tick(); tick();

        // 4. Three-cycle stall with a taken branch arriving during STALL.
        reset_pulse();
        memread = 1'b1; idex_rt = 5'd8; rs = 5'd8;
        @(negedge clk);
        chk("lit_ls3_state0", 1, 32'(st_o[1]), 32'd0);
        tick();
        memread = 1'b0; br = 1'b1;
        @(negedge clk);
        chk("lit_ls3_state1", 1, 32'(st_o[1]), 32'd1);
        chk("lit_ls3_noflush", 1, 32'(fl_o[1]), 32'd0);
        tick();
        @(negedge clk);
        chk("lit_ls3_state2", 1, 32'(st_o[1]), 32'd1);
        tick();
        @(negedge clk);
        chk("lit_ls3_state3", 1, 32'(st_o[1]), 32'd0);
        chk("lit_ls3_stall_cnt", 1, 32'(sc_o[1]), 32'd3);
        chk("lit_ls3_flush", 1, 32'(fl_o[1]), 32'd1);
        tick();
        idle(); tick();

        // 5. Hazard and branch together: bubble wins, then flush.
        reset_pulse();
        memread = 1'b1; idex_rt = 5'd8; rs = 5'd8; br = 1'b1;
        @(negedge clk);
        chk("lit_both_flush", 0, 32'(fl_o[0]), 32'd0);
        chk("lit_both_pc", 0, 32'(pc_o[0]), 32'd0);
        tick();
        memread = 1'b0;
        @(negedge clk);
        chk("lit_br_flush", 0, 32'(fl_o[0]), 32'd1);
        chk("lit_br_fcnt_pre", 0, 32'(fc_o[0]), 32'd0);
        tick();
        br = 1'b0;
        @(negedge clk);
        chk("lit_br_fcnt", 0, 32'(fc_o[0]), 32'd1);
        tick(); tick(); tick();

        // 6. Saturation with 2-bit counters, then reset mid-STALL.
        reset_pulse();
        br = 1'b1;
        repeat (5) tick();
        br = 1'b0;
        @(negedge clk);
        chk("lit_sat_fcnt_c", 2, 32'(fc_o[2]), 32'd3);
        chk("lit_sat_fcnt_a", 0, 32'(fc_o[0]), 32'd5);
        memread = 1'b1; idex_rt = 5'd8; rs = 5'd8;
        tick();
        memread = 1'b0;
        @(negedge clk);
        chk("lit_mid_state", 1, 32'(st_o[1]), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("lit_abort_state", 1, 32'(st_o[1]), 32'd0);
        chk("lit_abort_scnt", 1, 32'(sc_o[1]), 32'd0);
        chk("lit_abort_fcnt", 0, 32'(fc_o[0]), 32'd0);
        tick();
        rst = 1'b1;
        tick(); tick();
        running = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
